// File: rtl/seg_pkg.sv
// Shared constants for the stack seven-segment display.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  localparam logic [3:0] AN_D0 = 4'b1110;
  localparam logic [3:0] AN_D1 = 4'b1101;
  localparam logic [3:0] AN_D2 = 4'b1011;
  localparam logic [3:0] AN_D3 = 4'b0111;
  localparam logic [3:0] AN_OFF = 4'b1111;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic [1:0] {
    DIG0,
    DIG1,
    DIG2,
    DIG3
  } digit_e;

endpackage

// File: rtl/stack_seg_display_if.sv
// Stack-to-display bundle: data byte, load strobe,
// error indication and error clear strobe.
interface stack_seg_display_if;
  logic [7:0] data_in;
  logic       load;
  logic       error_in;
  logic       err_clr;

  modport master (
    output data_in,
    output load,
    output error_in,
    output err_clr
  );

  modport slave (
    input data_in,
    input load,
    input error_in,
    input err_clr
  );
endinterface

// File: rtl/seg_hex_decode.sv
// Nibble to active-low seven-segment pattern.
// Purely combinational table lookup.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/stack_seg_display.sv
// 4-digit multiplexed display of the stack output byte
// with a sticky, blinking error indication.
module stack_seg_display
  import seg_pkg::*;
#(
  parameter int REFRESH_BITS = 18,
  parameter int BLINK_BITS   = 26
) (
  input  logic                clk,
  input  logic                reset_n,
  stack_seg_display_if.slave  bus,
  output logic [3:0]          an,
  output logic [6:0]          seg,
  output logic                dp
);

  logic [7:0]              held_q, held_d;
  logic                    err_q, err_d;
  logic [REFRESH_BITS-1:0] ref_q, ref_d;
  logic [BLINK_BITS-1:0]   blink_q, blink_d;
  digit_e                  sel_q, sel_d;
  logic [3:0]              an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [3:0]              nib;
  logic [6:0]              hex_seg;

  assign nib = (sel_q == DIG1) ? held_q[7:4] : held_q[3:0];

  seg_hex_decode u_dec (
    .nib_i (nib),
    .seg_o (hex_seg)
  );

  // Next state: capture, sticky error (set wins), scan counters.
  always_comb begin
    held_d  = bus.load ? bus.data_in : held_q;
    err_d   = bus.error_in | (err_q & ~bus.err_clr);
    ref_d   = ref_q + 1'b1;
    blink_d = blink_q + 1'b1;
    sel_d   = (&ref_q) ? digit_e'(sel_q + 2'd1) : sel_q;
  end

  // Digit mux feeding the output registers.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    unique case (sel_q)
      DIG0: begin
        an_d  = AN_D0;
        seg_d = hex_seg;
      end
      DIG1: begin
        an_d  = AN_D1;
        seg_d = hex_seg;
      end
      DIG2: begin
        an_d = AN_D2;
        dp_d = ~err_q;
      end
      DIG3: begin
        an_d = AN_D3;
        if (err_q && !blink_q[BLINK_BITS-1])
          seg_d = SEG_E;
      end
      default: ;
    endcase
  end

  // State and output registers; reset blanks the display.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_q  <= 8'h00;
      err_q   <= 1'b0;
      ref_q   <= '0;
      blink_q <= '0;
      sel_q   <= DIG0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      held_q  <= held_d;
      err_q   <= err_d;
      ref_q   <= ref_d;
      blink_q <= blink_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_stack_seg_display.sv
// Scoreboard bench for stack_seg_display with
// REFRESH_BITS=2, BLINK_BITS=4.
module tb_stack_seg_display;

  logic       clk;
  logic       reset_n;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  stack_seg_display_if bus ();

  stack_seg_display #(
    .REFRESH_BITS (2),
    .BLINK_BITS   (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  logic [11:0] sb [$];
  logic [3:0]  last_an;

  int         m_sel;
  int         m_ref;
  logic [7:0] m_held;
  bit         m_err;
  logic [3:0] m_blink;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [11:0] exp_out(input int sel,
                                          input logic [7:0] h,
                                          input bit e,
                                          input logic [3:0] b);
    case (sel)
      0: return {4'b1110, hex7(h[3:0]), 1'b1};
      1: return {4'b1101, hex7(h[7:4]), 1'b1};
      2: return {4'b1011, 7'h7F, ~e};
      default:
        return {4'b0111, (e && !b[3]) ? 7'b0000110 : 7'h7F, 1'b1};
    endcase
  endfunction

  task automatic model_reset();
    m_sel   = 0;
    m_ref   = 0;
    m_held  = 8'h00;
    m_err   = 1'b0;
    m_blink = 4'h0;
  endtask

  task automatic step(input logic ld, input logic [7:0] d,
                      input logic e, input logic c);
    logic [11:0] exp;
    logic [11:0] got;
    bus.load     = ld;
    bus.data_in  = d;
    bus.error_in = e;
    bus.err_clr  = c;
    exp = exp_out(m_sel, m_held, m_err, m_blink);
    sb.push_back(exp);
    @(posedge clk);
    if (ld) m_held = d;
    if (e) m_err = 1'b1;
    else if (c) m_err = 1'b0;
    if (m_ref == 3) m_sel = (m_sel + 1) % 4;
    m_ref   = (m_ref + 1) % 4;
    m_blink = m_blink + 4'd1;
    #1;
    got = {an, seg, dp};
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      exp = sb.pop_front();
      last_an = exp[11:8];
      chk("scan", {20'd0, got}, {20'd0, exp});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic find_d2(input logic [7:0] d);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      step(1'b0, d, 1'b0, 1'b0);
      if (last_an == 4'b1011) found = 1'b1;
    end
    chk("find_d2", {31'd0, found}, 32'd1);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    last_an = 4'hF;
    bus.load     = 1'b0;
    bus.data_in  = 8'h00;
    bus.error_in = 1'b0;
    bus.err_clr  = 1'b0;
    reset_n = 1'b0;
    model_reset();

    // 1. reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold", {20'd0, an, seg, dp}, {20'd0, 4'b1111, 7'h7F, 1'b1});
    end
    reset_n = 1'b1;

    // 2. free-run scan
    idle(32);

    // 3. load A5, then change data without load
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    idle(16);
    for (int i = 0; i < 16; i++)
      step(1'b0, 8'h5A, 1'b0, 1'b0);

    // 4. one-cycle error pulse, watch blink
    step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(40);

    // 5. set and clear together, then clear alone
    step(1'b0, 8'h00, 1'b1, 1'b1);
    idle(20);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(36);

    // 6. async reset while digit 2 is shown
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    find_d2(8'h00);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst", {20'd0, an, seg, dp}, {20'd0, 4'b1111, 7'h7F, 1'b1});
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold2", {20'd0, an, seg, dp}, {20'd0, 4'b1111, 7'h7F, 1'b1});
    reset_n = 1'b1;
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_seg_display.md
Name: stack_seg_display

Overview:
- Downstream consumer of the stack's data_out/error pair; drives a 4-digit, common-anode, time-multiplexed seven-segment display.
- Captures the byte on a load strobe and shows it as two hex digits (digits 1:0).
- Holds a sticky error indication: a blinking 'E' on digit 3 and a steady decimal point on digit 2.
- All outputs are registered and active-low.

Parameters:
- REFRESH_BITS, 18, width of the free-running refresh counter; each digit is shown for 2^REFRESH_BITS cycles.
- BLINK_BITS, 26, width of the blink counter; the MSB is the blink phase.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- data_in  in  8  byte to display (stack data_out)
- load  in  1  1-cycle strobe; capture data_in
- error_in  in  1  stack error; sets the sticky error flag
- err_clr  in  1  1-cycle strobe; clears the sticky error flag
- an  out  4  digit enables, active-low; an[0] is the rightmost digit
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

Behaviour:
Reset:
- reset_n low asynchronously forces an=4'b1111, seg=7'h7F, dp=1.
- The same assertion clears held_data to 8'h00, err_flag to 0, digit_sel to 0 and both counters to 0.
- This applies at any time, including mid-scan.

Capture:
- load=1 at edge k sets held_data<=data_in.
- seg reflects the new value from edge k+1 onward, whenever that digit is selected.
- load=0 holds held_data.

Error flag:
- Set when error_in=1.
- Cleared when err_clr=1 and error_in=0.
- If error_in=1 and err_clr=1 in the same cycle, set wins.

Scan:
- refresh_cnt increments every cycle and wraps.
- When refresh_cnt is all ones, digit_sel increments on that edge (0->1->2->3->0).
- an/seg/dp are registered from digit_sel, held_data and err_flag, so they lag digit_sel by exactly 1 cycle.
- Each digit stays active for exactly 2^REFRESH_BITS cycles.
- First post-reset edge: an=4'b1110, showing digit 0.

Digit content:
- digit 0: an=1110, seg=hex(held_data[3:0]), dp=1.
- digit 1: an=1101, seg=hex(held_data[7:4]), dp=1.
- digit 2: an=1011, seg=7'h7F (blank), dp=~err_flag.
- digit 3: an=0111, dp=1.
  - seg=7'b0000110 ('E') when err_flag=1 and blink_cnt MSB=0.
  - Otherwise seg=7'h7F.

Blink counter:
- blink_cnt free-runs and wraps; it is never cleared except by reset.

Hex table (active-low gfedcba):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110

General rules:
- No combinational path from any input to any output.
- An output changes only at a clock edge or on asynchronous reset.

Decomposition:
- Shared package seg_pkg holds:
  - the hex-to-segment constant table (16 x 7-bit);
  - SEG_BLANK=7'h7F;
  - SEG_E=7'b0000110;
  - digit enable constants AN_D0..AN_D3.
- One sub-module, seg_hex_decode: a purely combinational 4-bit to 7-bit decoder using the package table.
- Counters, flags, digit mux and output registers stay in stack_seg_display.

Test Plan (bench uses REFRESH_BITS=2, BLINK_BITS=4):
1. Hold reset_n=0 for 3 cycles, then release -> during reset an=1111, seg=7F, dp=1. The first edge after release gives an=1110 and seg=1000000 (digit 0 of held_data=00).
2. Free-run 32 cycles -> an cycles 1110, 1101, 1011, 0111, each held exactly 4 consecutive cycles, then repeats.
3. Pulse load with data_in=8'hA5 -> when digit 0 is active, seg=0010010; when digit 1 is active, seg=0001000. A later data_in change with load=0 leaves the display unchanged.
4. Pulse error_in for 1 cycle -> digit 2 shows dp=0 persistently. Digit 3 shows seg=0000110 when blink MSB=0 and 7F when MSB=1, across 32+ cycles.
5. Assert error_in and err_clr in the same cycle -> flag stays set (dp=0 on digit 2). A later err_clr alone -> dp=1 and digit 3 is blank thereafter.
6. Load 8'h3C, set the error flag, then pull reset_n low while an=1011 -> outputs go to 1111/7F/1 with no clock edge. After release, digit 0 shows 1000000 and no error is indicated.
